// File: rtl/grayscale_pipe.sv
// Pipelined RGB-to-luma converter with frame tracking, per-frame output mode and sync-error flag.
// Three register stages: weighted products, rounded/saturated luma, output mux.
module grayscale_pipe #(
  parameter int unsigned COLOR_W = 10,
  parameter int unsigned WR      = 77,
  parameter int unsigned WG      = 150,
  parameter int unsigned WB      = 29,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned FRAME_W = 640,
  parameter int unsigned FRAME_H = 480
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic [COLOR_W-1:0] i_red,
  input  logic [COLOR_W-1:0] i_green,
  input  logic [COLOR_W-1:0] i_blue,
  input  logic [1:0]         i_mode,
  input  logic [COLOR_W-1:0] i_threshold,
  input  logic               i_clr_err,
  output logic               o_valid,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic [COLOR_W-1:0] o_gray,
  output logic               o_sof,
  output logic               o_eof,
  output logic               o_frame_done,
  output logic               o_sync_err
);

  localparam int unsigned PW = COLOR_W + FRAC;
  localparam int unsigned SW = COLOR_W + FRAC + 2;
  localparam int unsigned XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [COLOR_W-1:0] CMAX = '1;
  localparam logic [SW-1:0]      RND  = SW'(1) << (FRAC - 1);

  typedef enum logic {S_IDLE, S_FRAME} state_e;

  state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d, pos_x;
  logic [YW-1:0] y_q, y_d, pos_y;
  logic [1:0] mode_q, mode_d;
  logic [COLOR_W-1:0] thr_q, thr_d;
  logic err_q, err_d;
  logic accept, last_x, beat_eof;

  logic s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
  logic [XW-1:0] s1_x_q, s1_x_d;
  logic [1:0] s1_mode_q, s1_mode_d;
  logic [COLOR_W-1:0] s1_thr_q, s1_thr_d, s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
  logic [PW-1:0] s1_pr_q, s1_pr_d, s1_pg_q, s1_pg_d, s1_pb_q, s1_pb_d;

  logic s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d, s2_eof_q, s2_eof_d;
  logic [XW-1:0] s2_x_q, s2_x_d;
  logic [1:0] s2_mode_q, s2_mode_d;
  logic [COLOR_W-1:0] s2_thr_q, s2_thr_d, s2_r_q, s2_r_d, s2_g_q, s2_g_d, s2_b_q, s2_b_d;
  logic [COLOR_W-1:0] s2_luma_q, s2_luma_d;
  logic [SW-1:0] sum, shifted;

  logic out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d, done_q, done_d;
  logic [COLOR_W-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d, out_gray_q, out_gray_d;
  logic [COLOR_W-1:0] bw;

  // Frame tracking: a sof beat always restarts at (0,0); counters hold the next expected position.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    thr_d    = thr_q;
    err_d    = err_q & ~i_clr_err;
    accept   = 1'b0;
    pos_x    = i_sof ? '0 : x_q;
    pos_y    = i_sof ? '0 : y_q;
    last_x   = (pos_x == XW'(FRAME_W - 1));
    beat_eof = last_x && (pos_y == YW'(FRAME_H - 1));
    if (i_valid) begin
      if (i_sof) begin
        accept = 1'b1;
        mode_d = i_mode;
        thr_d  = i_threshold;
        if (state_q == S_FRAME) err_d = 1'b1;
      end else if (state_q == S_FRAME) begin
        accept = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (accept) begin
      state_d = S_FRAME;
      x_d     = pos_x + XW'(1);
      y_d     = pos_y;
      if (beat_eof) begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
      end else if (last_x) begin
        x_d = '0;
        y_d = pos_y + YW'(1);
      end
    end
  end

  // Datapath; data fields hold through bubbles, mode/threshold travel with each pixel.
  always_comb begin
    s1_valid_d = accept;
    s1_sof_d = s1_sof_q;   s1_eof_d = s1_eof_q;   s1_x_d = s1_x_q;
    s1_mode_d = s1_mode_q; s1_thr_d = s1_thr_q;
    s1_r_d = s1_r_q;       s1_g_d = s1_g_q;       s1_b_d = s1_b_q;
    s1_pr_d = s1_pr_q;     s1_pg_d = s1_pg_q;     s1_pb_d = s1_pb_q;
    if (accept) begin
      s1_sof_d  = i_sof;
      s1_eof_d  = beat_eof;
      s1_x_d    = pos_x;
      s1_mode_d = mode_d;
      s1_thr_d  = thr_d;
      s1_r_d    = i_red;
      s1_g_d    = i_green;
      s1_b_d    = i_blue;
      s1_pr_d   = PW'(i_red) * PW'(WR);
      s1_pg_d   = PW'(i_green) * PW'(WG);
      s1_pb_d   = PW'(i_blue) * PW'(WB);
    end

    sum     = SW'(s1_pr_q) + SW'(s1_pg_q) + SW'(s1_pb_q) + RND;
    shifted = sum >> FRAC;
    s2_valid_d = s1_valid_q;
    s2_sof_d = s2_sof_q;   s2_eof_d = s2_eof_q;   s2_x_d = s2_x_q;
    s2_mode_d = s2_mode_q; s2_thr_d = s2_thr_q;
    s2_r_d = s2_r_q;       s2_g_d = s2_g_q;       s2_b_d = s2_b_q;
    s2_luma_d = s2_luma_q;
    if (s1_valid_q) begin
      s2_sof_d  = s1_sof_q;
      s2_eof_d  = s1_eof_q;
      s2_x_d    = s1_x_q;
      s2_mode_d = s1_mode_q;
      s2_thr_d  = s1_thr_q;
      s2_r_d    = s1_r_q;
      s2_g_d    = s1_g_q;
      s2_b_d    = s1_b_q;
      s2_luma_d = (shifted > SW'(CMAX)) ? CMAX : COLOR_W'(shifted);
    end

    bw          = (s2_luma_q > s2_thr_q) ? CMAX : '0;
    out_valid_d = s2_valid_q;
    out_sof_d   = s2_valid_q & s2_sof_q;
    out_eof_d   = s2_valid_q & s2_eof_q;
    done_d      = out_valid_q & out_eof_q;
    out_r_d = out_r_q; out_g_d = out_g_q; out_b_d = out_b_q; out_gray_d = out_gray_q;
    if (s2_valid_q) begin
      out_gray_d = s2_luma_q;
      unique case (s2_mode_q)
        2'd0: begin out_r_d = s2_luma_q; out_g_d = s2_luma_q; out_b_d = s2_luma_q; end
        2'd1: begin out_r_d = bw;        out_g_d = bw;        out_b_d = bw;        end
        2'd2: begin out_r_d = s2_r_q;    out_g_d = s2_g_q;    out_b_d = s2_b_q;    end
        default: begin
          if (s2_x_q < XW'(FRAME_W / 2)) begin
            out_r_d = s2_luma_q; out_g_d = s2_luma_q; out_b_d = s2_luma_q;
          end else begin
            out_r_d = s2_r_q;    out_g_d = s2_g_q;    out_b_d = s2_b_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE; x_q <= '0; y_q <= '0; mode_q <= '0; thr_q <= '0; err_q <= 1'b0;
      s1_valid_q <= 1'b0; s1_sof_q <= 1'b0; s1_eof_q <= 1'b0; s1_x_q <= '0;
      s1_mode_q <= '0; s1_thr_q <= '0; s1_r_q <= '0; s1_g_q <= '0; s1_b_q <= '0;
      s1_pr_q <= '0; s1_pg_q <= '0; s1_pb_q <= '0;
      s2_valid_q <= 1'b0; s2_sof_q <= 1'b0; s2_eof_q <= 1'b0; s2_x_q <= '0;
      s2_mode_q <= '0; s2_thr_q <= '0; s2_r_q <= '0; s2_g_q <= '0; s2_b_q <= '0;
      s2_luma_q <= '0;
      out_valid_q <= 1'b0; out_sof_q <= 1'b0; out_eof_q <= 1'b0; done_q <= 1'b0;
      out_r_q <= '0; out_g_q <= '0; out_b_q <= '0; out_gray_q <= '0;
    end else begin
      state_q <= state_d; x_q <= x_d; y_q <= y_d; mode_q <= mode_d; thr_q <= thr_d; err_q <= err_d;
      s1_valid_q <= s1_valid_d; s1_sof_q <= s1_sof_d; s1_eof_q <= s1_eof_d; s1_x_q <= s1_x_d;
      s1_mode_q <= s1_mode_d; s1_thr_q <= s1_thr_d; s1_r_q <= s1_r_d; s1_g_q <= s1_g_d; s1_b_q <= s1_b_d;
      s1_pr_q <= s1_pr_d; s1_pg_q <= s1_pg_d; s1_pb_q <= s1_pb_d;
      s2_valid_q <= s2_valid_d; s2_sof_q <= s2_sof_d; s2_eof_q <= s2_eof_d; s2_x_q <= s2_x_d;
      s2_mode_q <= s2_mode_d; s2_thr_q <= s2_thr_d; s2_r_q <= s2_r_d; s2_g_q <= s2_g_d; s2_b_q <= s2_b_d;
      s2_luma_q <= s2_luma_d;
      out_valid_q <= out_valid_d; out_sof_q <= out_sof_d; out_eof_q <= out_eof_d; done_q <= done_d;
      out_r_q <= out_r_d; out_g_q <= out_g_d; out_b_q <= out_b_d; out_gray_q <= out_gray_d;
    end
  end

  assign o_valid      = out_valid_q;
  assign o_red        = out_r_q;
  assign o_green      = out_g_q;
  assign o_blue       = out_b_q;
  assign o_gray       = out_gray_q;
  assign o_sof        = out_sof_q;
  assign o_eof        = out_eof_q;
  assign o_frame_done = done_q;
  assign o_sync_err   = err_q;

endmodule

// File: tb/tb_grayscale_pipe.sv
// Directed self-checking bench for grayscale_pipe on a 4x2 frame.
module tb_grayscale_pipe;
  localparam int unsigned CW = 10;
  localparam int unsigned FW = 4;
  localparam int unsigned FH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_valid = 1'b0, i_sof = 1'b0, i_clr_err = 1'b0;
  logic [CW-1:0] i_red = '0, i_green = '0, i_blue = '0, i_threshold = '0;
  logic [1:0] i_mode = '0;
  logic o_valid, o_sof, o_eof, o_frame_done, o_sync_err;
  logic [CW-1:0] o_red, o_green, o_blue, o_gray;

  grayscale_pipe #(.COLOR_W(CW), .FRAME_W(FW), .FRAME_H(FH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue), .i_mode(i_mode),
    .i_threshold(i_threshold), .i_clr_err(i_clr_err),
    .o_valid(o_valid), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_gray(o_gray), .o_sof(o_sof), .o_eof(o_eof), .o_frame_done(o_frame_done),
    .o_sync_err(o_sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sof; logic eof;
    logic [CW-1:0] r; logic [CW-1:0] g; logic [CW-1:0] b; logic [CW-1:0] gray;
  } beat_t;

  beat_t q[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, eof_cyc = -1, done_cyc = -1, done_cnt = 0;

  // Output beat recorder plus eof/frame_done timing.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_valid) q.push_back({o_sof, o_eof, o_red, o_green, o_blue, o_gray});
    if (o_valid && o_eof) eof_cyc <= cyc;
    if (o_frame_done) begin
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
  end

  function automatic logic [CW-1:0] luma(input int r, input int g, input int b);
    int s;
    s = (r * 77 + g * 150 + b * 29 + 128) >>> 8;
    return (s > 1023) ? 10'd1023 : CW'(s);
  endfunction

  task automatic step(input logic v, input logic s, input logic [CW-1:0] r, input logic [CW-1:0] g,
                      input logic [CW-1:0] b);
    i_valid = v; i_sof = s; i_red = r; i_green = g; i_blue = b;
    @(posedge clk); #1;
    i_valid = 1'b0; i_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    i_valid = 0; i_sof = 0; i_clr_err = 0; i_mode = 0; i_threshold = 0;
    rst_n = 0;
    idle(2);
    rst_n = 1;
    idle(1);
    q.delete();
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({o_valid, o_red, o_green, o_blue, o_gray, o_sof, o_eof, o_frame_done, o_sync_err} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {o_valid, o_red, o_green, o_blue, o_gray, o_sof, o_eof, o_frame_done, o_sync_err});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_gray_white();
    do_reset();
    step(1, 1, 10'd1023, 10'd1023, 10'd1023);
    idle(1);
    n_checks++;
    if (o_valid !== 1'b0) $display("FAIL latency_early: o_valid got %b want 0", o_valid); else n_pass++;
    idle(1);
    n_checks++;
    if (o_valid !== 1'b1) $display("FAIL latency3: o_valid got %b want 1", o_valid); else n_pass++;
    n_checks++;
    if (o_gray !== 10'd1023) $display("FAIL white_gray: got %0d want 1023", o_gray); else n_pass++;
    n_checks++;
    if ({o_red, o_green, o_blue} !== {3{10'd1023}})
      $display("FAIL white_rgb: got %0d %0d %0d want 1023", o_red, o_green, o_blue);
    else n_pass++;
    n_checks++;
    if ({o_sof, o_eof} !== 2'b10) $display("FAIL white_flags: sof/eof got %b want 10", {o_sof, o_eof});
    else n_pass++;
    idle(1);
    n_checks++;
    if ({o_valid, o_sof, o_gray} !== {2'b00, 10'd1023})
      $display("FAIL bubble_hold: valid/sof/gray got %b%b %0d want 00 1023", o_valid, o_sof, o_gray);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 1, 10'd1023, 10'd0, 10'd0);
    step(1, 0, 10'd0, 10'd1023, 10'd0);
    step(1, 0, 10'd0, 10'd0, 10'd1023);
    n_checks++;
    if ({o_valid, o_gray, o_red} !== {1'b1, 10'd308, 10'd308})
      $display("FAIL red_luma: valid/gray/red got %b %0d %0d want 1 308 308", o_valid, o_gray, o_red);
    else n_pass++;
    idle(1);
    n_checks++;
    if ({o_valid, o_sof, o_gray} !== {2'b10, 10'd599})
      $display("FAIL green_luma: valid/sof/gray got %b%b %0d want 10 599", o_valid, o_sof, o_gray);
    else n_pass++;
    idle(1);
    n_checks++;
    if ({o_valid, o_red, o_green, o_blue, o_gray} !== {1'b1, {4{10'd116}}})
      $display("FAIL blue_luma: valid %b rgb %0d %0d %0d gray %0d want 1 116", o_valid, o_red, o_green,
               o_blue, o_gray);
    else n_pass++;
  endtask

  task automatic test_bw();
    do_reset();
    i_mode = 2'd1; i_threshold = 10'd20;
    step(1, 1, 10'd20, 10'd20, 10'd20);
    i_threshold = 10'd0; i_mode = 2'd0;
    step(1, 0, 10'd21, 10'd21, 10'd21);
    step(1, 0, 10'd20, 10'd20, 10'd20);
    n_checks++;
    if ({o_red, o_green, o_blue, o_gray} !== {30'd0, 10'd20})
      $display("FAIL bw_eq_thr: rgb %0d %0d %0d gray %0d want 0 0 0 20", o_red, o_green, o_blue, o_gray);
    else n_pass++;
    idle(1);
    n_checks++;
    if ({o_red, o_green, o_blue, o_gray} !== {{3{10'd1023}}, 10'd21})
      $display("FAIL bw_above: rgb %0d %0d %0d gray %0d want 1023x3 21", o_red, o_green, o_blue, o_gray);
    else n_pass++;
    idle(1);
    n_checks++;
    if ({o_red, o_green, o_blue} !== 30'd0)
      $display("FAIL bw_latched_thr: rgb %0d %0d %0d want 0", o_red, o_green, o_blue);
    else n_pass++;
  endtask

  task automatic test_frame_split();
    logic [7:0] bub;
    logic [CW-1:0] r[8], g[8], b[8], ex;
    int done0;
    do_reset();
    bub = 8'b0101_1010;
    done0 = done_cnt;
    i_mode = 2'd3;
    for (int i = 0; i < 8; i++) begin
      r[i] = CW'(100 + 37 * i); g[i] = CW'(900 - 50 * i); b[i] = CW'(17 * i + 5);
      step(1, i == 0, r[i], g[i], b[i]);
      if (bub[i]) idle(1);
    end
    idle(5);
    n_checks++;
    if (q.size() !== 8) $display("FAIL frame_beats: got %0d want 8", q.size()); else n_pass++;
    if (q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        ex = luma(int'(r[i]), int'(g[i]), int'(b[i]));
        n_checks++;
        if ((i % 4) < 2) begin
          if ({q[i].r, q[i].g, q[i].b, q[i].gray} !== {ex, ex, ex, ex})
            $display("FAIL split_gray[%0d]: got %0d %0d %0d want %0d", i, q[i].r, q[i].g, q[i].b, ex);
          else n_pass++;
        end else begin
          if ({q[i].r, q[i].g, q[i].b, q[i].gray} !== {r[i], g[i], b[i], ex})
            $display("FAIL split_pass[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", i, q[i].r,
                     q[i].g, q[i].b, q[i].gray, r[i], g[i], b[i], ex);
          else n_pass++;
        end
        n_checks++;
        if ({q[i].sof, q[i].eof} !== {i == 0, i == 7})
          $display("FAIL frame_flags[%0d]: sof/eof got %b want %b", i, {q[i].sof, q[i].eof},
                   {i == 0, i == 7});
        else n_pass++;
      end
    end
    n_checks++;
    if (done_cnt - done0 !== 1 || done_cyc !== eof_cyc + 1)
      $display("FAIL frame_done: pulses %0d at cyc %0d, eof cyc %0d; want 1 pulse at eof+1",
               done_cnt - done0, done_cyc, eof_cyc);
    else n_pass++;
    n_checks++;
    if (o_sync_err !== 1'b0) $display("FAIL clean_frame_err: got %b want 0", o_sync_err); else n_pass++;
    step(1, 0, 10'd1, 10'd1, 10'd1);
    idle(4);
    n_checks++;
    if (q.size() !== 8 || o_sync_err !== 1'b1)
      $display("FAIL back_to_idle: beats %0d err %b want 8 1", q.size(), o_sync_err);
    else n_pass++;
  endtask

  task automatic test_sync_err();
    do_reset();
    step(1, 0, 10'd5, 10'd5, 10'd5);
    idle(4);
    n_checks++;
    if (q.size() !== 0 || o_sync_err !== 1'b1)
      $display("FAIL idle_no_sof: beats %0d err %b want 0 1", q.size(), o_sync_err);
    else n_pass++;
    i_clr_err = 1; idle(1); i_clr_err = 0;
    n_checks++;
    if (o_sync_err !== 1'b0) $display("FAIL clr_err: got %b want 0", o_sync_err); else n_pass++;
    for (int i = 0; i < 13; i++) step(1, i == 0 || i == 5, CW'(10 * i), CW'(7 * i), CW'(3 * i));
    idle(5);
    n_checks++;
    if (q.size() !== 13 || o_sync_err !== 1'b1)
      $display("FAIL mid_sof: beats %0d err %b want 13 1", q.size(), o_sync_err);
    else n_pass++;
    if (q.size() == 13) begin
      for (int i = 0; i < 13; i++) begin
        n_checks++;
        if ({q[i].sof, q[i].eof} !== {i == 0 || i == 5, i == 12})
          $display("FAIL restart_flags[%0d]: sof/eof got %b want %b", i, {q[i].sof, q[i].eof},
                   {i == 0 || i == 5, i == 12});
        else n_pass++;
      end
    end
    i_clr_err = 1; idle(1); i_clr_err = 0;
    n_checks++;
    if (o_sync_err !== 1'b0) $display("FAIL clr_err2: got %b want 0", o_sync_err); else n_pass++;
    i_clr_err = 1;
    step(1, 0, 10'd9, 10'd9, 10'd9);
    i_clr_err = 0;
    n_checks++;
    if (o_sync_err !== 1'b1) $display("FAIL err_beats_clr: got %b want 1", o_sync_err); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    step(1, 1, 10'd500, 10'd500, 10'd500);
    step(1, 0, 10'd400, 10'd400, 10'd400);
    step(1, 0, 10'd300, 10'd300, 10'd300);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({o_valid, o_red, o_green, o_blue, o_gray, o_sof, o_eof, o_frame_done, o_sync_err} !== '0)
      $display("FAIL async_reset: got %h want 0",
               {o_valid, o_red, o_green, o_blue, o_gray, o_sof, o_eof, o_frame_done, o_sync_err});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1;
    idle(6);
    n_checks++;
    if (q.size() !== 0) $display("FAIL flushed: beats got %0d want 0", q.size()); else n_pass++;
    step(1, 0, 10'd8, 10'd8, 10'd8);
    idle(4);
    n_checks++;
    if (q.size() !== 0) $display("FAIL need_sof: beats got %0d want 0", q.size()); else n_pass++;
    step(1, 1, 10'd300, 10'd300, 10'd300);
    idle(3);
    n_checks++;
    if (q.size() !== 1) $display("FAIL new_sof: beats got %0d want 1", q.size());
    else if ({q[0].sof, q[0].gray} !== {1'b1, 10'd300})
      $display("FAIL new_sof: sof/gray got %b %0d want 1 300", q[0].sof, q[0].gray);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_gray_white();
    test_back_to_back();
    test_bw();
    test_frame_split();
    test_sync_err();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
